axis_pkt_arbiter: RTL

Packet-level round-robin arbiter that shares the 64-bit primary AXI-Stream input of axi_cdc among NUM_SRC requesters in the primary clock domain. It also drives the bridge's cfg[1:0], taking each granted source's configuration. cfg changes only on packet boundaries, so it is stable for every beat of a packet. It sits directly upstream of axi_cdc, on clk_p.

---
 rtl/axis_arb_pkg.sv | 18 +
 rtl/rr_pick.sv | 36 +++
 rtl/axis_pkt_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the packet-level AXI-Stream arbiter.
package axis_arb_pkg;

  localparam int CFG_W = 2;

  typedef logic [CFG_W-1:0] cfg_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_e;

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
  import axis_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  localparam int IW = idx_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [IW-1:0]      gnt_idx,
  output logic               any
);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    sum     = '0;
    cand    = '0;
    // Walk from the farthest offset down so the nearest requester wins last.
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IW + 1)'(k);
      if (sum >= (IW + 1)'(NUM_SRC)) begin
        sum = sum - (IW + 1)'(NUM_SRC);
      end
      cand = sum[IW-1:0];
      if (req[cand]) begin
        gnt_idx = cand;
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-level round-robin arbiter feeding one AXI-Stream port, with per-packet cfg and a beat watchdog.
module axis_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int WIDTH     = 64,
  parameter int MAX_BEATS = 256,
  localparam int IW = idx_w(NUM_SRC),
  localparam int CW = idx_w(MAX_BEATS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [CFG_W*NUM_SRC-1:0]   src_cfg,
  input  logic [WIDTH*NUM_SRC-1:0]   in_axis_data,
  input  logic [NUM_SRC-1:0]         in_axis_valid,
  input  logic [NUM_SRC-1:0]         in_axis_last,
  output logic [NUM_SRC-1:0]         in_axis_ready,
  output logic [WIDTH-1:0]           out_axis_data,
  output logic                       out_axis_valid,
  output logic                       out_axis_last,
  input  logic                       out_axis_ready,
  output logic [CFG_W-1:0]           cfg,
  output logic [IW-1:0]              grant_id,
  output logic                       busy,
  output logic                       trunc_err
);

  // Handshake: a beat moves when valid and ready are both high at a posedge.
  // valid/data/last from the granted source pass straight through; ready flows back
  // only to that source, so a stall simply holds everything in place.

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    rr_q, gid_q, rr_next;
  cfg_t             cfg_q;
  logic [CW-1:0]    cnt_q;
  logic             trunc_q;

  logic [WIDTH-1:0] data_arr [NUM_SRC];
  cfg_t             cfg_arr  [NUM_SRC];

  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic             grant_go, wd_hit, sel_valid, sel_last, beat_acc, pkt_end;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_slice
    assign data_arr[i] = in_axis_data[i*WIDTH +: WIDTH];
    assign cfg_arr[i]  = src_cfg[i*CFG_W +: CFG_W];
  end

  rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .req     (in_axis_valid),
    .ptr     (rr_q),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  assign sel_valid = in_axis_valid[gid_q];
  assign sel_last  = in_axis_last[gid_q];
  assign wd_hit    = (cnt_q == CW'(MAX_BEATS - 1));
  assign grant_go  = (state_q == ST_IDLE) && en && pick_any;
  assign beat_acc  = (state_q == ST_XFER) && sel_valid && out_axis_ready;
  assign pkt_end   = beat_acc && (sel_last || wd_hit);
  assign rr_next   = (gid_q == IW'(NUM_SRC - 1)) ? '0 : gid_q + 1'b1;

  always_comb begin
    state_d        = state_q;
    out_axis_data  = data_arr[gid_q];
    out_axis_valid = 1'b0;
    out_axis_last  = 1'b0;
    in_axis_ready  = '0;
    case (state_q)
      ST_IDLE: begin
        if (grant_go) state_d = ST_XFER;
      end
      ST_XFER: begin
        out_axis_valid       = sel_valid;
        out_axis_last        = sel_last || wd_hit;
        in_axis_ready[gid_q] = out_axis_ready;
        if (pkt_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      gid_q   <= '0;
      cfg_q   <= '0;
      cnt_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_go) begin
        gid_q <= pick_idx;
        cfg_q <= cfg_arr[pick_idx];
        cnt_q <= '0;
      end
      if (pkt_end) begin
        rr_q  <= rr_next;
        cnt_q <= '0;
        // A forced last leaves the source mid-packet; its tail re-arbitrates later.
        if (!sel_last) trunc_q <= 1'b1;
      end else if (beat_acc) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign cfg       = cfg_q;
  assign grant_id  = gid_q;
  assign busy      = (state_q == ST_XFER);
  assign trunc_err = trunc_q;

endmodule
